core_run_ctrl: RTL

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl_if.sv | 35 +++
 rtl/core_run_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/core_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// core_run_ctrl_if
// Command channel into the core run controller.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid_i and
// cmd_ready_o are both 1. The controller keeps cmd_ready_o at 1, so every
// strobe is accepted and acts on that same edge. The master holds cmd_op_i
// and cmd_data_i stable whenever cmd_valid_i is 1.
//
// Signals:
//   cmd_valid_i  master -> slave  command strobe
//   cmd_ready_o  slave  -> master command accepted (always 1)
//   cmd_op_i     master -> slave  3-bit opcode
//   cmd_data_i   master -> slave  32-bit operand (breakpoint address)
// -----------------------------------------------------------------------------
interface core_run_ctrl_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [31:0] cmd_data_i;

  modport master (
    output cmd_valid_i,
    output cmd_op_i,
    output cmd_data_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_op_i,
    input  cmd_data_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
// Run/halt/step controller for a simple core. Gates the core with a
// registered enable, stops on a PC breakpoint, single-steps one retire,
// and detects program completion (jump-to-self below FINISH_LIMIT), at
// which point it captures x10 and parks in FINISHED until reset.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cmd             command channel (slave modport of core_run_ctrl_if)
//   pc_i, instr_i   PC / encoding of the instruction retiring this cycle
//   retire_i        one instruction retires (ignored while core_en_o=0)
//   result_i        live value of x10
//   core_en_o       core advance enable (registered)
//   state_o         0 HALTED, 1 RUNNING, 2 STEPPING, 3 FINISHED
//   halt_cause_o    0 NONE, 1 CMD, 2 BP, 3 STEP, 4 FINISH
//   cycle_cnt_o     enabled cycles, saturating
//   retire_cnt_o    enabled retires, saturating
//   result_o        x10 captured at finish
//   done_o          sticky finish flag
// -----------------------------------------------------------------------------
module core_run_ctrl #(
  parameter logic [31:0] FINISH_LIMIT = 32'h0000_0020,
  parameter logic [31:0] FINISH_INSTR = 32'h0000_006f,
  parameter bit          BOOT_RUN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_run_ctrl_if.slave        cmd,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           instr_i,
  input  logic                  retire_i,
  input  logic [31:0]           result_i,
  output logic                  core_en_o,
  output logic [1:0]            state_o,
  output logic [2:0]            halt_cause_o,
  output logic [31:0]           cycle_cnt_o,
  output logic [31:0]           retire_cnt_o,
  output logic [31:0]           result_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2,
    ST_FINISHED = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_CMD    = 3'd1,
    CAUSE_BP     = 3'd2,
    CAUSE_STEP   = 3'd3,
    CAUSE_FINISH = 3'd4
  } cause_e;

  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_CNT = 3'd6;

  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;
  localparam state_e      BOOT_STATE = BOOT_RUN ? ST_RUNNING : ST_HALTED;

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic        core_en_q, core_en_d;
  logic        bp_en_q, bp_en_d;
  logic [31:0] bp_addr_q, bp_addr_d;
  logic        bp_skip_q, bp_skip_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic cmd_acc;
  logic cmd_run, cmd_halt, cmd_step, cmd_set_bp, cmd_clr_bp, cmd_clr_cnt;
  logic retire_eff, finish_hit, bp_hit, step_done;

  assign cmd.cmd_ready_o = 1'b1;
  assign cmd_acc         = cmd.cmd_valid_i & cmd.cmd_ready_o;

  assign cmd_run     = cmd_acc && (cmd.cmd_op_i == OP_RUN);
  assign cmd_halt    = cmd_acc && (cmd.cmd_op_i == OP_HALT);
  assign cmd_step    = cmd_acc && (cmd.cmd_op_i == OP_STEP);
  assign cmd_set_bp  = cmd_acc && (cmd.cmd_op_i == OP_SET_BP);
  assign cmd_clr_bp  = cmd_acc && (cmd.cmd_op_i == OP_CLR_BP);
  assign cmd_clr_cnt = cmd_acc && (cmd.cmd_op_i == OP_CLR_CNT);

  // A retire only counts while the core is actually enabled.
  assign retire_eff = retire_i & core_en_q;
  assign finish_hit = retire_eff && (pc_i < FINISH_LIMIT) && (instr_i == FINISH_INSTR);
  // bp_skip_q exempts the first retire after leaving HALTED so a resume
  // sitting on the breakpoint PC can get past it.
  assign bp_hit     = (state_q == ST_RUNNING) && retire_eff && bp_en_q &&
                      (pc_i == bp_addr_q) && !bp_skip_q;
  assign step_done  = (state_q == ST_STEPPING) && retire_eff;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    bp_en_d      = bp_en_q;
    bp_addr_d    = bp_addr_q;
    bp_skip_d    = bp_skip_q;
    done_d       = done_q;
    result_d     = result_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;

    // Counters: clear beats increment; saturate instead of wrapping.
    if (cmd_clr_cnt) begin
      cycle_cnt_d  = '0;
      retire_cnt_d = '0;
    end else if (core_en_q) begin
      if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (retire_i && (retire_cnt_q != CNT_MAX)) retire_cnt_d = retire_cnt_q + 32'd1;
    end

    if (retire_eff) bp_skip_d = 1'b0;

    // Breakpoint programming is frozen once the program has finished.
    if (state_q != ST_FINISHED) begin
      if (cmd_set_bp) begin
        bp_en_d   = 1'b1;
        bp_addr_d = cmd.cmd_data_i;
      end else if (cmd_clr_bp) begin
        bp_en_d = 1'b0;
      end
    end

    // Priority inside the enabled states: FINISH > BP > STEP > HALT.
    case (state_q)
      ST_HALTED: begin
        if (cmd_run) begin
          state_d   = ST_RUNNING;
          cause_d   = CAUSE_NONE;
          bp_skip_d = 1'b1;
        end else if (cmd_step) begin
          state_d   = ST_STEPPING;
          cause_d   = CAUSE_NONE;
          bp_skip_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (finish_hit) begin
          state_d  = ST_FINISHED;
          cause_d  = CAUSE_FINISH;
          done_d   = 1'b1;
          result_d = result_i;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (cmd_halt) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end
      end
      ST_STEPPING: begin
        if (finish_hit) begin
          state_d  = ST_FINISHED;
          cause_d  = CAUSE_FINISH;
          done_d   = 1'b1;
          result_d = result_i;
        end else if (step_done) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STEP;
        end else if (cmd_halt) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CMD;
        end
      end
      default: begin
        // FINISHED: only reset leaves this state.
      end
    endcase

    core_en_d = (state_d == ST_RUNNING) || (state_d == ST_STEPPING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT_STATE;
      cause_q      <= CAUSE_NONE;
      core_en_q    <= BOOT_RUN;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= '0;
      bp_skip_q    <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      core_en_q    <= core_en_d;
      bp_en_q      <= bp_en_d;
      bp_addr_q    <= bp_addr_d;
      bp_skip_q    <= bp_skip_d;
      done_q       <= done_d;
      result_q     <= result_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign core_en_o    = core_en_q;
  assign state_o      = state_q;
  assign halt_cause_o = cause_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
  assign result_o     = result_q;
  assign done_o       = done_q;

endmodule
